// File: rtl/pmem_line_responder_pkg.sv
// Shared types for the pmem line responder: line/word/beat types and the burst FSM state.
package pmem_line_responder_pkg;

    localparam int unsigned PMEM_BEATS  = 8;
    localparam int unsigned PMEM_WORD_W = 16;
    localparam int unsigned PMEM_LINE_W = PMEM_WORD_W * PMEM_BEATS;

    typedef logic [PMEM_WORD_W-1:0] lc3b_word;
    typedef logic [PMEM_LINE_W-1:0] lc3b_line;
    typedef logic [2:0]             lc3b_beat;

    typedef enum logic [1:0] {
        StIdle,
        StReadBurst,
        StWriteBurst,
        StResp
    } pmem_state_t;

endpackage

// File: rtl/pmem_line_responder_line.sv
// Line staging buffer: whole-line load, word-indexed write, word-indexed read mux.
module pmem_line_buffer
    import pmem_line_responder_pkg::*;
#(
    parameter int unsigned WORD_W = PMEM_WORD_W,
    parameter int unsigned BEATS  = PMEM_BEATS
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_load,
    input  logic [WORD_W*BEATS-1:0] i_line,
    input  logic                    i_we,
    input  lc3b_beat                i_beat,
    input  logic [WORD_W-1:0]       i_wdata,
    output logic [WORD_W-1:0]       o_word,
    output logic [WORD_W*BEATS-1:0] o_line
);

    logic [WORD_W*BEATS-1:0] r_line;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_line <= '0;
        end else if (i_load) begin
            r_line <= i_line;
        end else if (i_we) begin
            r_line[i_beat*WORD_W +: WORD_W] <= i_wdata;
        end
    end

    assign o_word = r_line[i_beat*WORD_W +: WORD_W];
    assign o_line = r_line;

endmodule

// File: rtl/pmem_line_responder.sv
// Turns 128-bit pmem line reads/writebacks into 8-beat 16-bit req/ack bursts.
// Optional per-beat watchdog enabled by defining PMEM_TIMEOUT_EN.
module pmem_line_responder
    import pmem_line_responder_pkg::*;
#(
    parameter int unsigned WORD_W   = PMEM_WORD_W,
    parameter int unsigned BEATS    = PMEM_BEATS,
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    pmem_read,
    input  logic                    pmem_write,
    input  logic [15:0]             pmem_address,
    input  logic [WORD_W*BEATS-1:0] pmem_wdata,
    output logic [WORD_W*BEATS-1:0] pmem_rdata,
    output logic                    pmem_resp,
    output logic                    pmem_err,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [15:0]             mem_addr,
    output logic [WORD_W-1:0]       mem_wdata,
    input  logic                    mem_ack,
    input  logic [WORD_W-1:0]       mem_rdata
);

    localparam int unsigned LINE_W    = WORD_W * BEATS;
    localparam lc3b_beat    LAST_BEAT = lc3b_beat'(BEATS - 1);

    pmem_state_t       r_state, w_state_next;
    lc3b_beat          r_beat, w_beat_next;
    logic              r_mem_req, w_mem_req_next;
    logic              r_mem_we, w_mem_we_next;
    logic [11:0]       r_line_addr, w_line_addr_next;
    logic [LINE_W-1:0] r_rdata;
    logic              w_rdata_upd;
    logic              w_buf_load;
    logic              w_buf_we;
    logic [WORD_W-1:0] w_buf_word;
    logic [LINE_W-1:0] w_buf_line;
    logic              w_timeout;
    logic              w_unused;

    assign w_unused = ^pmem_address[3:0];

`ifdef PMEM_TIMEOUT_EN
    logic [7:0] r_wait;
    logic       r_err;

    assign w_timeout = r_mem_req & ~mem_ack & (r_wait == 8'(MAX_WAIT - 1));

    // r_err is high only in the RESP cycle that follows a timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait <= '0;
            r_err  <= 1'b0;
        end else begin
            r_wait <= (r_mem_req && !mem_ack) ? r_wait + 8'd1 : 8'd0;
            r_err  <= w_timeout;
        end
    end

    assign pmem_err = r_err;
`else
    logic w_unused_cfg;
    assign w_unused_cfg = ^MAX_WAIT;
    assign w_timeout    = 1'b0;
    assign pmem_err     = 1'b0;
`endif

    always_comb begin
        w_state_next     = r_state;
        w_beat_next      = r_beat;
        w_mem_req_next   = r_mem_req;
        w_mem_we_next    = r_mem_we;
        w_line_addr_next = r_line_addr;
        w_buf_load       = 1'b0;
        w_buf_we         = 1'b0;
        w_rdata_upd      = 1'b0;
        unique case (r_state)
            StIdle: begin
                // Write wins if both are requested.
                if (pmem_write) begin
                    w_line_addr_next = pmem_address[15:4];
                    w_beat_next      = '0;
                    w_mem_req_next   = 1'b1;
                    w_mem_we_next    = 1'b1;
                    w_buf_load       = 1'b1;
                    w_state_next     = StWriteBurst;
                end else if (pmem_read) begin
                    w_line_addr_next = pmem_address[15:4];
                    w_beat_next      = '0;
                    w_mem_req_next   = 1'b1;
                    w_mem_we_next    = 1'b0;
                    w_state_next     = StReadBurst;
                end
            end
            StReadBurst, StWriteBurst: begin
                if (r_mem_req && mem_ack) begin
                    w_buf_we    = (r_state == StReadBurst);
                    w_beat_next = r_beat + 1'b1;
                    if (r_beat == LAST_BEAT) begin
                        w_mem_req_next = 1'b0;
                        w_rdata_upd    = (r_state == StReadBurst);
                        w_state_next   = StResp;
                    end
                end else if (w_timeout) begin
                    w_mem_req_next = 1'b0;
                    w_beat_next    = '0;
                    w_state_next   = StResp;
                end
            end
            StResp: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_beat      <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_line_addr <= '0;
            r_rdata     <= '0;
        end else begin
            r_state     <= w_state_next;
            r_beat      <= w_beat_next;
            r_mem_req   <= w_mem_req_next;
            r_mem_we    <= w_mem_we_next;
            r_line_addr <= w_line_addr_next;
            // Final beat lands in the top word the same edge the buffer captures it.
            if (w_rdata_upd) begin
                r_rdata <= {mem_rdata, w_buf_line[LINE_W-WORD_W-1:0]};
            end
        end
    end

    pmem_line_buffer #(
        .WORD_W (WORD_W),
        .BEATS  (BEATS)
    ) u_line_buffer (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_buf_load),
        .i_line  (pmem_wdata),
        .i_we    (w_buf_we),
        .i_beat  (r_beat),
        .i_wdata (mem_rdata),
        .o_word  (w_buf_word),
        .o_line  (w_buf_line)
    );

    assign pmem_rdata = r_rdata;
    assign pmem_resp  = (r_state == StResp);
    assign mem_req    = r_mem_req;
    assign mem_we     = r_mem_we & r_mem_req;
    assign mem_addr   = {r_line_addr, r_beat, 1'b0};
    assign mem_wdata  = w_buf_word;

endmodule

// File: tb/tb_pmem_line_responder.sv
// Directed bench for pmem_line_responder with a narrow-bus responder model.
module tb_pmem_line_responder;

`ifdef PMEM_TIMEOUT_EN
    localparam int unsigned TB_MAX_WAIT = 20;
`else
    localparam int unsigned TB_MAX_WAIT = 255;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         pmem_read = 1'b0;
    logic         pmem_write = 1'b0;
    logic [15:0]  pmem_address = '0;
    logic [127:0] pmem_wdata = '0;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;
    logic         pmem_err;
    logic         mem_req;
    logic         mem_we;
    logic [15:0]  mem_addr;
    logic [15:0]  mem_wdata;
    logic         mem_ack = 1'b0;
    logic [15:0]  mem_rdata = '0;

    pmem_line_responder #(
        .WORD_W   (16),
        .BEATS    (8),
        .MAX_WAIT (TB_MAX_WAIT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .pmem_err     (pmem_err),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Responder model state
    int           dly[8] = '{0, 0, 0, 0, 0, 0, 0, 0};
    int           stall_beat = -1;
    int           wait_cnt = 0;
    logic         stray_ack = 1'b0;
    logic [15:0]  rd_base = 16'h1000;
    logic [15:0]  log_addr[$];
    logic [15:0]  log_wdata[$];
    logic         log_we[$];
    int           resp_count = 0;
    int           resp_cyc = 0;
    int           req_cycles = 0;
    int           stall_cycles = 0;
    logic         resp_err = 1'b0;
    logic [127:0] resp_rdata = '0;

    always @(negedge clk) begin
        mem_ack = 1'b0;
        if (pmem_resp) begin
            resp_count++;
            resp_cyc   = cyc;
            resp_err   = pmem_err;
            resp_rdata = pmem_rdata;
        end
        if (mem_req) begin
            req_cycles++;
            if (log_addr.size() == stall_beat) stall_cycles++;
            if (log_addr.size() != stall_beat && wait_cnt >= dly[log_addr.size() % 8]) begin
                mem_ack   = 1'b1;
                mem_rdata = rd_base + {13'd0, mem_addr[3:1]};
                log_addr.push_back(mem_addr);
                log_we.push_back(mem_we);
                log_wdata.push_back(mem_wdata);
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
            mem_ack  = stray_ack;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic run_burst(input logic rd, input logic wr, input logic [15:0] addr,
                             input logic [127:0] wdata, output int start);
        log_addr.delete();
        log_we.delete();
        log_wdata.delete();
        resp_count   = 0;
        req_cycles   = 0;
        stall_cycles = 0;
        pmem_read    = rd;
        pmem_write   = wr;
        pmem_address = addr;
        pmem_wdata   = wdata;
        start        = cyc;
        for (int i = 0; i < 400; i++) begin
            step();
            if (resp_count != 0) break;
        end
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        repeat (3) step();
    endtask

    task automatic test_reset();
        step();
        step();
        total++;
        if ({mem_req, mem_we, pmem_resp, pmem_err} !== 4'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got %b want 0000", {mem_req, mem_we, pmem_resp, pmem_err});
        end
        total++;
        if (mem_addr !== 16'h0000) begin
            bad++;
            $display("FAIL reset_addr: got %h want 0000", mem_addr);
        end
        total++;
        if (mem_wdata !== 16'h0000) begin
            bad++;
            $display("FAIL reset_wdata: got %h want 0000", mem_wdata);
        end
        total++;
        if (pmem_rdata !== 128'h0) begin
            bad++;
            $display("FAIL reset_rdata: got %h want 0", pmem_rdata);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_read_zero_wait();
        int start;
        dly     = '{0, 0, 0, 0, 0, 0, 0, 0};
        rd_base = 16'h1000;
        run_burst(1'b1, 1'b0, 16'h0A3C, 128'h0, start);
        total++;
        if (resp_count != 1) begin
            bad++;
            $display("FAIL rd_resp_count: got %0d want 1", resp_count);
        end
        total++;
        if (resp_cyc - start + 1 != 10) begin
            bad++;
            $display("FAIL rd_latency: got %0d want 10", resp_cyc - start + 1);
        end
        total++;
        if (log_addr.size() != 8) begin
            bad++;
            $display("FAIL rd_beats: got %0d want 8", log_addr.size());
        end
        for (int i = 0; i < log_addr.size(); i++) begin
            total++;
            if (log_addr[i] !== 16'h0A30 + 16'(2 * i) || log_we[i] !== 1'b0) begin
                bad++;
                $display("FAIL rd_beat[%0d]: got addr %h we %b want addr %h we 0", i,
                         log_addr[i], log_we[i], 16'h0A30 + 16'(2 * i));
            end
        end
        total++;
        if (resp_rdata !== 128'h1007_1006_1005_1004_1003_1002_1001_1000) begin
            bad++;
            $display("FAIL rd_line: got %h want 1007..1000", resp_rdata);
        end
        total++;
        if (resp_err !== 1'b0) begin
            bad++;
            $display("FAIL rd_err: got %b want 0", resp_err);
        end
    endtask

    task automatic test_write();
        int start;
        logic [15:0] exp_w[8];
        exp_w = '{16'h3210, 16'h7654, 16'hBA98, 16'hFEDC, 16'hCDEF, 16'h89AB, 16'h4567, 16'h0123};
        dly   = '{0, 0, 0, 0, 0, 0, 0, 0};
        run_burst(1'b0, 1'b1, 16'h4000, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, start);
        total++;
        if (resp_count != 1 || log_addr.size() != 8) begin
            bad++;
            $display("FAIL wr_resp: got resp %0d beats %0d want 1 and 8", resp_count,
                     log_addr.size());
        end
        for (int i = 0; i < log_addr.size(); i++) begin
            total++;
            if (log_wdata[i] !== exp_w[i] || log_we[i] !== 1'b1 ||
                log_addr[i] !== 16'h4000 + 16'(2 * i)) begin
                bad++;
                $display("FAIL wr_beat[%0d]: got %h/%b/%h want %h/1/%h", i, log_wdata[i],
                         log_we[i], log_addr[i], exp_w[i], 16'h4000 + 16'(2 * i));
            end
        end
        total++;
        if (pmem_rdata !== 128'h1007_1006_1005_1004_1003_1002_1001_1000) begin
            bad++;
            $display("FAIL wr_rdata_held: got %h want 1007..1000", pmem_rdata);
        end
        total++;
        if (mem_we !== 1'b0) begin
            bad++;
            $display("FAIL wr_we_idle: got %b want 0", mem_we);
        end
    endtask

    task automatic test_random_delay();
        int start;
        dly     = '{3, 0, 5, 1, 4, 2, 0, 5};
        rd_base = 16'h2A00;
        run_burst(1'b1, 1'b0, 16'h1230, 128'h0, start);
        total++;
        if (resp_count != 1) begin
            bad++;
            $display("FAIL dly_resp_count: got %0d want 1", resp_count);
        end
        total++;
        if (req_cycles != 28) begin
            bad++;
            $display("FAIL dly_req_cycles: got %0d want 28", req_cycles);
        end
        total++;
        if (resp_cyc - start + 1 != 30) begin
            bad++;
            $display("FAIL dly_latency: got %0d want 30", resp_cyc - start + 1);
        end
        total++;
        if (pmem_rdata !== 128'h2A07_2A06_2A05_2A04_2A03_2A02_2A01_2A00) begin
            bad++;
            $display("FAIL dly_line: got %h want 2A07..2A00", pmem_rdata);
        end
    endtask

    task automatic test_both_high();
        int start;
        int we_ones;
        logic [15:0] exp_w[8];
        exp_w = '{16'h8888, 16'h9999, 16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD, 16'hEEEE, 16'hFFFF};
        dly   = '{0, 0, 0, 0, 0, 0, 0, 0};
        run_burst(1'b1, 1'b1, 16'h8000, 128'hFFFF_EEEE_DDDD_CCCC_BBBB_AAAA_9999_8888, start);
        we_ones = 0;
        for (int i = 0; i < log_we.size(); i++) if (log_we[i] === 1'b1) we_ones++;
        total++;
        if (we_ones != 8 || resp_count != 1) begin
            bad++;
            $display("FAIL both_we: got we beats %0d resp %0d want 8 and 1", we_ones, resp_count);
        end
        for (int i = 0; i < log_wdata.size(); i++) begin
            total++;
            if (log_wdata[i] !== exp_w[i]) begin
                bad++;
                $display("FAIL both_wdata[%0d]: got %h want %h", i, log_wdata[i], exp_w[i]);
            end
        end
        total++;
        if (pmem_rdata !== 128'h2A07_2A06_2A05_2A04_2A03_2A02_2A01_2A00) begin
            bad++;
            $display("FAIL both_rdata_held: got %h want 2A07..2A00", pmem_rdata);
        end
    endtask

    task automatic test_reset_mid();
        int start;
        dly        = '{1, 1, 1, 1, 1, 1, 1, 1};
        rd_base    = 16'h3000;
        log_addr.delete();
        log_we.delete();
        log_wdata.delete();
        resp_count   = 0;
        pmem_read    = 1'b1;
        pmem_address = 16'h0500;
        for (int i = 0; i < 100; i++) begin
            step();
            if (log_addr.size() >= 4) break;
        end
        @(posedge clk);
        #1;
        total++;
        if (mem_req !== 1'b1 || mem_addr !== 16'h0508) begin
            bad++;
            $display("FAIL mid_pre: got req %b addr %h want 1 0508", mem_req, mem_addr);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (mem_req !== 1'b0 || mem_addr !== 16'h0000 || pmem_rdata !== 128'h0) begin
            bad++;
            $display("FAIL mid_abort: got req %b addr %h rdata %h want 0 0000 0", mem_req,
                     mem_addr, pmem_rdata);
        end
        pmem_read = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        repeat (12) step();
        total++;
        if (resp_count != 0) begin
            bad++;
            $display("FAIL mid_no_resp: got %0d want 0", resp_count);
        end
        dly     = '{0, 0, 0, 0, 0, 0, 0, 0};
        rd_base = 16'h5500;
        run_burst(1'b1, 1'b0, 16'h0010, 128'h0, start);
        total++;
        if (resp_count != 1 || pmem_rdata !== 128'h5507_5506_5505_5504_5503_5502_5501_5500) begin
            bad++;
            $display("FAIL mid_after: got resp %0d line %h want 1 5507..5500", resp_count,
                     pmem_rdata);
        end
        total++;
        if (log_addr.size() < 1 || log_addr[0] !== 16'h0010) begin
            bad++;
            $display("FAIL mid_after_addr: got %0d beats want first addr 0010", log_addr.size());
        end
    endtask

    task automatic test_stray_ack();
        resp_count = 0;
        stray_ack  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if (mem_req !== 1'b0) begin
                bad++;
                $display("FAIL stray_req[%0d]: got %b want 0", i, mem_req);
            end
        end
        stray_ack = 1'b0;
        repeat (2) step();
        total++;
        if (resp_count != 0) begin
            bad++;
            $display("FAIL stray_resp: got %0d want 0", resp_count);
        end
    endtask

`ifdef PMEM_TIMEOUT_EN
    task automatic test_timeout();
        int start;
        dly        = '{0, 0, 0, 0, 0, 0, 0, 0};
        rd_base    = 16'h7700;
        stall_beat = 2;
        run_burst(1'b1, 1'b0, 16'h0C00, 128'h0, start);
        stall_beat = -1;
        total++;
        if (resp_count != 1 || resp_err !== 1'b1) begin
            bad++;
            $display("FAIL to_resp: got resp %0d err %b want 1 1", resp_count, resp_err);
        end
        total++;
        if (stall_cycles != 20 || log_addr.size() != 2) begin
            bad++;
            $display("FAIL to_wait: got %0d cycles %0d beats want 20 and 2", stall_cycles,
                     log_addr.size());
        end
        total++;
        if (pmem_rdata !== 128'h5507_5506_5505_5504_5503_5502_5501_5500) begin
            bad++;
            $display("FAIL to_rdata_held: got %h want 5507..5500", pmem_rdata);
        end
        total++;
        if (pmem_err !== 1'b0) begin
            bad++;
            $display("FAIL to_err_clear: got %b want 0", pmem_err);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_read_zero_wait();
        test_write();
        test_random_delay();
        test_both_high();
        test_reset_mid();
        test_stray_ack();
`ifdef PMEM_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
